// File: rtl/seq_controller_pkg.sv
// Shared types and control decode for the accumulator-machine sequencer.
// Opcode and state encodings match the datapath's instruction format.
package seq_controller_pkg;

    localparam int MEM_WAIT_MAX = 7;

    typedef enum logic [3:0] {
        OP_HLT  = 4'd0,
        OP_SKZ  = 4'd1,
        OP_ADD  = 4'd2,
        OP_AND  = 4'd3,
        OP_XOR  = 4'd4,
        OP_LDA  = 4'd5,
        OP_STO  = 4'd6,
        OP_JMP  = 4'd7,
        OP_SUB  = 4'd8,
        OP_OR   = 4'd9,
        OP_SKNZ = 4'd10,
        OP_JZ   = 4'd11,
        OP_NOP  = 4'd12
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    typedef struct packed {
        logic mem_rd;
        logic load_ir;
        logic halt;
        logic inc_pc;
        logic load_ac;
        logic load_pc;
        logic mem_wr;
        logic instr_done;
    } ctrl_t;

    // Moore decode; hdone marks the first cycle after leaving HALTED.
    function automatic ctrl_t decode(state_t s, opcode_t op, logic z,
                                     logic sticky, logic hdone);
        ctrl_t c;
        logic  aluop;
        logic  skip;
        logic  take;
        c     = '0;
        aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
                (op == OP_LDA) || (op == OP_SUB) || (op == OP_OR);
        skip  = ((op == OP_SKZ) && z) || ((op == OP_SKNZ) && !z);
        take  = (op == OP_JMP) || ((op == OP_JZ) && z);
        case (s)
            INST_ADDR:  c.instr_done = hdone;
            INST_FETCH: c.mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                c.mem_rd  = 1'b1;
                c.load_ir = 1'b1;
            end
            OP_ADDR: begin
                c.inc_pc = 1'b1;
                c.halt   = (op == OP_HLT) && !sticky;
            end
            OP_FETCH: c.mem_rd = aluop;
            ALU_OP: begin
                c.mem_rd  = aluop;
                c.load_ac = aluop;
                c.inc_pc  = skip;
                c.load_pc = take;
            end
            STORE: begin
                c.mem_rd     = aluop;
                c.load_ac    = aluop;
                c.inc_pc     = take;
                c.load_pc    = take;
                c.mem_wr     = (op == OP_STO);
                c.instr_done = 1'b1;
            end
            HALTED:  c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_wait_cnt.sv
// Fetch-state wait counter: saturating 3-bit count of cycles spent in the
// current fetch state, and the ready-qualified exit condition.
module seq_wait_cnt
    import seq_controller_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_mem_ready,
    output logic o_done
);

    logic [2:0] r_cnt;

    // Clearing on exit as well as while idle means every entry sees zero.
    always_ff @(posedge clk) begin
        if (rst || !i_en || o_done) begin
            r_cnt <= 3'd0;
        end else if (r_cnt != 3'(MEM_WAIT_MAX)) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_done = i_en && i_mem_ready && (r_cnt >= 3'(MEM_WAIT));

endmodule

// File: rtl/seq_controller.sv
// Instruction sequencer: steps the fixed fetch/execute cycle and drives the
// datapath controls as registered outputs decoded from the next state.
module seq_controller
    import seq_controller_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int MEM_WAIT    = 0,
    parameter int HALT_STICKY = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    input  logic           resume,
    output logic           mem_rd,
    output logic           load_ir,
    output logic           halt,
    output logic           inc_pc,
    output logic           load_ac,
    output logic           load_pc,
    output logic           mem_wr,
    output logic           instr_done,
    output state_t         state
);

    localparam logic STICKY = (HALT_STICKY != 0);

    state_t  r_state;
    opcode_t r_op;
    logic    r_z;
    ctrl_t   r_ctrl;

    state_t  w_state_next;
    opcode_t w_op_next;
    logic    w_z_next;
    logic    w_hdone;
    logic    w_fetch;
    logic    w_done;

    assign w_fetch = (r_state == INST_FETCH) || (r_state == OP_FETCH);

    seq_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_fetch),
        .i_mem_ready (mem_ready),
        .o_done      (w_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_z_next     = r_z;
        w_hdone      = 1'b0;
        case (r_state)
            INST_ADDR:  w_state_next = INST_FETCH;
            INST_FETCH: if (w_done) w_state_next = INST_LOAD;
            INST_LOAD:  w_state_next = IDLE;
            IDLE: begin
                w_state_next = OP_ADDR;
                w_op_next    = opcode_t'(4'(opcode));
            end
            OP_ADDR:
                w_state_next = ((r_op == OP_HLT) && STICKY) ? HALTED : OP_FETCH;
            OP_FETCH: begin
                if (w_done) begin
                    w_state_next = ALU_OP;
                    w_z_next     = zero;
                end
            end
            ALU_OP: w_state_next = STORE;
            STORE:  w_state_next = INST_ADDR;
            HALTED: begin
                if (resume) begin
                    w_state_next = INST_ADDR;
                    w_hdone      = 1'b1;
                end
            end
            default: w_state_next = INST_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INST_ADDR;
            r_op    <= OP_HLT;
            r_z     <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_z     <= w_z_next;
            r_ctrl  <= decode(w_state_next, w_op_next, w_z_next, STICKY, w_hdone);
        end
    end

    assign mem_rd     = r_ctrl.mem_rd;
    assign load_ir    = r_ctrl.load_ir;
    assign halt       = r_ctrl.halt;
    assign inc_pc     = r_ctrl.inc_pc;
    assign load_ac    = r_ctrl.load_ac;
    assign load_pc    = r_ctrl.load_pc;
    assign mem_wr     = r_ctrl.mem_wr;
    assign instr_done = r_ctrl.instr_done;
    assign state      = r_state;

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench: two sequencer configurations share random stimulus and
// are compared cycle by cycle against a step-list reference model.
module tb_seq_controller;
    import seq_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       resume = 1'b0;

    wire [7:0] a_ctrl;
    wire [7:0] b_ctrl;
    state_t    a_state;
    state_t    b_state;

    seq_controller #(.OPW(4), .MEM_WAIT(0), .HALT_STICKY(0)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .mem_rd(a_ctrl[7]), .load_ir(a_ctrl[6]), .halt(a_ctrl[5]),
        .inc_pc(a_ctrl[4]), .load_ac(a_ctrl[3]), .load_pc(a_ctrl[2]),
        .mem_wr(a_ctrl[1]), .instr_done(a_ctrl[0]), .state(a_state)
    );

    seq_controller #(.OPW(3), .MEM_WAIT(3), .HALT_STICKY(1)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode[2:0]), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .mem_rd(b_ctrl[7]), .load_ir(b_ctrl[6]), .halt(b_ctrl[5]),
        .inc_pc(b_ctrl[4]), .load_ac(b_ctrl[3]), .load_pc(b_ctrl[2]),
        .mem_wr(b_ctrl[1]), .instr_done(b_ctrl[0]), .state(b_state)
    );

    // p: position in the step list 0..7, 8 = parked in HALTED.
    typedef struct {
        int p;
        int cnt;
        int op;
        bit z;
        bit hd;
    } ms_t;

    typedef struct {
        int          cyc;
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ms_t mstep(ms_t s, int mw, bit sticky, int opw,
                                  bit r, int opc, bit zr, bit mr, bit res);
        ms_t n;
        n    = s;
        n.hd = 1'b0;
        if (r) begin
            n.p = 0; n.cnt = 0; n.op = 0; n.z = 1'b0;
            return n;
        end
        case (s.p)
            1, 5: begin
                if (s.cnt >= mw && mr) begin
                    n.p   = s.p + 1;
                    n.cnt = 0;
                    if (s.p == 5) n.z = zr;
                end else begin
                    n.cnt = (s.cnt < 7) ? s.cnt + 1 : 7;
                end
            end
            3: begin
                n.op = opc % (1 << opw);
                n.p  = 4;
            end
            4: n.p = (s.op == 0 && sticky) ? 8 : 5;
            7: n.p = 0;
            8: if (res) begin n.p = 0; n.hd = 1'b1; end
            default: n.p = s.p + 1;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] exp_out(ms_t s, bit sticky);
        bit alu, skip, take;
        bit rd, ir, h, inc, ac, pc, wr, dn;
        alu  = (s.op inside {2, 3, 4, 5, 8, 9});
        skip = (s.op == 1 && s.z) || (s.op == 10 && !s.z);
        take = (s.op == 7) || (s.op == 11 && s.z);
        {rd, ir, h, inc, ac, pc, wr, dn} = 8'd0;
        case (s.p)
            0: dn = s.hd;
            1: rd = 1'b1;
            2, 3: begin rd = 1'b1; ir = 1'b1; end
            4: begin inc = 1'b1; h = (s.op == 0) && !sticky; end
            5: rd = alu;
            6: begin rd = alu; ac = alu; inc = skip; pc = take; end
            7: begin
                rd = alu; ac = alu; inc = take; pc = take;
                wr = (s.op == 6); dn = 1'b1;
            end
            8: h = 1'b1;
            default: ;
        endcase
        return {4'(s.p), rd, ir, h, inc, ac, pc, wr, dn};
    endfunction

    // Monitor: outputs are presented every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_total++;
                if ({a_state, a_ctrl} !== e.a)
                    $display("FAIL cfg_a cyc=%0d got state=%0d ctrl=%b exp state=%0d ctrl=%b",
                             e.cyc, a_state, a_ctrl, e.a[11:8], e.a[7:0]);
                else n_pass++;
                n_total++;
                if ({b_state, b_ctrl} !== e.b)
                    $display("FAIL cfg_b cyc=%0d got state=%0d ctrl=%b exp state=%0d ctrl=%b",
                             e.cyc, b_state, b_ctrl, e.b[11:8], e.b[7:0]);
                else n_pass++;
                if (e.a[0]) $display("cfg_a instr_done cyc=%0d", e.cyc);
                if (e.b[0]) $display("cfg_b instr_done cyc=%0d", e.cyc);
            end
        end
    end

    // Driver: directed ADD loop with ready tied high, then random traffic.
    initial begin
        ms_t ma;
        ms_t mb;
        ma = '{0, 0, 0, 1'b0, 1'b0};
        mb = '{0, 0, 0, 1'b0, 1'b0};
        for (int k = 0; k < 2400; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) begin
                rst = 1'b1;
            end else if (k < 40) begin
                rst = 1'b0; mem_ready = 1'b1; opcode = 4'd2;
                zero = 1'b0; resume = 1'b0;
            end else begin
                rst       = ($urandom_range(0, 79) == 0);
                mem_ready = ($urandom_range(0, 9) < 7);
                zero      = 1'($urandom_range(0, 1));
                resume    = ($urandom_range(0, 7) == 0);
                opcode    = 4'($urandom_range(0, 15));
            end
            ma = mstep(ma, 0, 1'b0, 4, rst, int'(opcode), zero, mem_ready, resume);
            mb = mstep(mb, 3, 1'b1, 3, rst, int'(opcode), zero, mem_ready, resume);
            q.push_back('{cyc + 1, exp_out(ma, 1'b0), exp_out(mb, 1'b1)});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (q.size() != 0)
            $display("FAIL drain got %0d pending exp 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
